// File: rtl/kalman_frame_sched.sv
// Frame-rate sequencer feeding one measurement or coast value per frame to a Kalman core.
// Optional measurement gating against the last estimate is enabled by defining KALMAN_GATE_EN.
module kalman_frame_sched #(
  parameter int DISP_WIDTH = 11,
  parameter int MAX_COAST  = 3,
  parameter int TIMEOUT    = 32,
  parameter int GATE_DIST  = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_tick,
  input  logic                  meas_valid,
  input  logic [DISP_WIDTH-1:0] meas_x,
  input  logic [DISP_WIDTH-1:0] meas_y,
  output logic                  core_valid,
  input  logic                  core_ready,
  output logic [DISP_WIDTH-1:0] core_z_x,
  output logic [DISP_WIDTH-1:0] core_z_y,
  input  logic [DISP_WIDTH-1:0] core_x_new,
  input  logic [DISP_WIDTH-1:0] core_y_new,
  output logic [DISP_WIDTH-1:0] est_x,
  output logic [DISP_WIDTH-1:0] est_y,
  output logic                  est_valid,
  output logic                  coasting,
  output logic                  track_lost,
  output logic                  overrun,
  output logic                  timeout_err,
  output logic                  busy
);
  localparam int W   = DISP_WIDTH;
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [3:0]     MAXC    = 4'(MAX_COAST);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, PUBLISH} state_t;
  state_t state, state_nx;

  logic           buf_full;
  logic [W-1:0]   buf_x, buf_y, sel_x, sel_y;
  logic [3:0]     coast_cnt;
  logic [WDW-1:0] wd_cnt;
  logic           have_meas, gate_rej, meas_ok;
  logic           take_meas, take_coast, go_lost, wd_fire;

  // A same-cycle measurement takes priority over the buffered one.
  assign have_meas = meas_valid | buf_full;
  assign sel_x     = meas_valid ? meas_x : buf_x;
  assign sel_y     = meas_valid ? meas_y : buf_y;

`ifdef KALMAN_GATE_EN
  localparam logic [W:0] GATE = (W+1)'(GATE_DIST);
  logic       est_seen;
  logic [W:0] dx, dy, ax, ay;
  assign dx = {1'b0, sel_x} - {1'b0, est_x};
  assign dy = {1'b0, sel_y} - {1'b0, est_y};
  assign ax = dx[W] ? -dx : dx;
  assign ay = dy[W] ? -dy : dy;
  assign gate_rej = est_seen && !track_lost && ((ax > GATE) || (ay > GATE));
`else
  assign gate_rej = 1'b0;
`endif

  assign meas_ok    = have_meas && !gate_rej;
  assign busy       = (state != IDLE);
  assign core_valid = (state == ISSUE) && core_ready;

  always_comb begin
    state_nx   = state;
    take_meas  = 1'b0;
    take_coast = 1'b0;
    go_lost    = 1'b0;
    wd_fire    = 1'b0;
    case (state)
      IDLE: if (frame_tick) begin
        if (meas_ok)                take_meas  = 1'b1;
        else if (!track_lost) begin
          if (coast_cnt < MAXC)     take_coast = 1'b1;
          else                      go_lost    = 1'b1;
        end
        if (take_meas || take_coast) state_nx = ISSUE;
      end
      ISSUE: if (core_ready) state_nx = WAIT_BUSY;
      WAIT_BUSY: begin
        if (!core_ready)              state_nx = WAIT_DONE;
        else if (wd_cnt == WD_LAST) begin wd_fire = 1'b1; state_nx = IDLE; end
      end
      WAIT_DONE: begin
        if (core_ready)               state_nx = PUBLISH;
        else if (wd_cnt == WD_LAST) begin wd_fire = 1'b1; state_nx = IDLE; end
      end
      PUBLISH: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      buf_full    <= 1'b0;
      buf_x       <= '0;
      buf_y       <= '0;
      coast_cnt   <= '0;
      wd_cnt      <= '0;
      core_z_x    <= '0;
      core_z_y    <= '0;
      est_x       <= '0;
      est_y       <= '0;
      est_valid   <= 1'b0;
      coasting    <= 1'b0;
      track_lost  <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
`ifdef KALMAN_GATE_EN
      est_seen    <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      if (meas_valid) begin
        buf_x <= meas_x;
        buf_y <= meas_y;
      end
      if (state == IDLE && state_nx != IDLE) buf_full <= 1'b0;
      else if (meas_valid)                   buf_full <= 1'b1;

      if (take_meas) begin
        core_z_x   <= sel_x;
        core_z_y   <= sel_y;
        coast_cnt  <= '0;
        coasting   <= 1'b0;
        track_lost <= 1'b0;
      end
      if (take_coast) begin
        core_z_x  <= est_x;
        core_z_y  <= est_y;
        coast_cnt <= coast_cnt + 4'd1;
        coasting  <= 1'b1;
      end
      if (go_lost) track_lost <= 1'b1;

      // Watchdog restarts on each entry to a wait state.
      if (state_nx != state && (state_nx == WAIT_BUSY || state_nx == WAIT_DONE))
        wd_cnt <= '0;
      else if (state == WAIT_BUSY || state == WAIT_DONE)
        wd_cnt <= wd_cnt + 1'b1;
      if (wd_fire) timeout_err <= 1'b1;

      est_valid <= (state == PUBLISH);
      if (state == PUBLISH) begin
        est_x <= core_x_new;
        est_y <= core_y_new;
`ifdef KALMAN_GATE_EN
        est_seen <= 1'b1;
`endif
      end
      if (frame_tick && state != IDLE) overrun <= 1'b1;
    end
  end
endmodule

// File: tb/tb_kalman_frame_sched.sv
// Directed bench for kalman_frame_sched with a behavioural core (ready low 8 cycles, x_new=z_x+1, y_new=z_y+2).
module tb_kalman_frame_sched;
  localparam int W = 11;

  logic clk = 1'b0;
  logic reset, frame_tick, meas_valid;
  logic [W-1:0] meas_x, meas_y;
  logic core_valid;
  logic core_ready = 1'b1;
  logic [W-1:0] core_z_x, core_z_y;
  logic [W-1:0] core_x_new = '0, core_y_new = '0;
  logic [W-1:0] est_x, est_y;
  logic est_valid, coasting, track_lost, overrun, timeout_err, busy;
  logic hang;
  logic [3:0] bcnt = '0;
  logic [W-1:0] zx_l = '0, zy_l = '0;
  int checks = 0, failures = 0;

  kalman_frame_sched #(.DISP_WIDTH(W), .MAX_COAST(3), .TIMEOUT(32), .GATE_DIST(64)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .meas_valid(meas_valid),
    .meas_x(meas_x), .meas_y(meas_y), .core_valid(core_valid), .core_ready(core_ready),
    .core_z_x(core_z_x), .core_z_y(core_z_y), .core_x_new(core_x_new), .core_y_new(core_y_new),
    .est_x(est_x), .est_y(est_y), .est_valid(est_valid), .coasting(coasting),
    .track_lost(track_lost), .overrun(overrun), .timeout_err(timeout_err), .busy(busy));

  always #5 clk = ~clk;

  // Core model: drops ready on the accepted issue, stays busy 8 cycles unless hung.
  always @(posedge clk) begin
    if (core_valid && core_ready) begin
      core_ready <= 1'b0;
      bcnt       <= '0;
      zx_l       <= core_z_x;
      zy_l       <= core_z_y;
    end else if (!core_ready && !hang) begin
      if (bcnt == 4'd7) begin
        core_ready <= 1'b1;
        core_x_new <= zx_l + 11'd1;
        core_y_new <= zy_l + 11'd2;
      end else bcnt <= bcnt + 4'd1;
    end
  end

  task automatic load_meas(input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    meas_valid = 1'b1; meas_x = x; meas_y = y;
    @(negedge clk);
    meas_valid = 1'b0;
  endtask

  task automatic wait_core_idle();
    for (int i = 0; i < 60 && !core_ready; i++) @(negedge clk);
    checks++;
    if (core_ready !== 1'b1) begin
      failures++;
      $display("FAIL core_idle_wait actual=%b required=1", core_ready);
    end
  endtask

  // Tick in cycle 0 (optionally with a measurement), optional second tick+meas at cycle t2.
  task automatic run_frame(input int n, input logic m0, input logic [W-1:0] m0x, m0y,
                           input int t2, input logic [W-1:0] m2x, m2y,
                           output int v_at, output int v_cnt, output int e_at, output int e_cnt,
                           output int to_at, output logic [W-1:0] zx, zy);
    v_at = -1; v_cnt = 0; e_at = -1; e_cnt = 0; to_at = -1; zx = '0; zy = '0;
    @(negedge clk);
    frame_tick = 1'b1; meas_valid = m0; meas_x = m0x; meas_y = m0y;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (core_valid) begin
        v_cnt++;
        if (v_at < 0) begin v_at = k; zx = core_z_x; zy = core_z_y; end
      end
      if (est_valid) begin e_cnt++; if (e_at < 0) e_at = k; end
      if (timeout_err && to_at < 0) to_at = k;
      frame_tick = (k == t2);
      meas_valid = (k == t2);
      meas_x = m2x; meas_y = m2y;
    end
    frame_tick = 1'b0; meas_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; frame_tick = 1'b0; meas_valid = 1'b0; meas_x = '0; meas_y = '0; hang = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({core_valid, est_valid, coasting, track_lost, overrun, timeout_err, busy} !== 7'b0 ||
        est_x !== '0 || est_y !== '0 || core_z_x !== '0 || core_z_y !== '0) begin
      failures++;
      $display("FAIL reset_outputs actual flags=%b est=(%0d,%0d) z=(%0d,%0d) required all 0",
        {core_valid, est_valid, coasting, track_lost, overrun, timeout_err, busy},
        est_x, est_y, core_z_x, core_z_y);
    end
  endtask

  task automatic test_basic();
    int va, vc, ea, ec, ta; logic [W-1:0] zx, zy;
    load_meas(11'd100, 11'd200);
    run_frame(14, 1'b0, '0, '0, 0, '0, '0, va, vc, ea, ec, ta, zx, zy);
    checks++;
    if (va !== 1 || vc !== 1 || zx !== 11'd100 || zy !== 11'd200) begin
      failures++;
      $display("FAIL basic_issue actual at=%0d cnt=%0d z=(%0d,%0d) required at=1 cnt=1 z=(100,200)", va, vc, zx, zy);
    end
    checks++;
    if (ea !== 12 || ec !== 1) begin
      failures++;
      $display("FAIL basic_latency actual at=%0d cnt=%0d required at=12 cnt=1", ea, ec);
    end
    checks++;
    if (est_x !== 11'd101 || est_y !== 11'd202 || coasting !== 1'b0) begin
      failures++;
      $display("FAIL basic_est actual=(%0d,%0d) coast=%b required=(101,202) coast=0", est_x, est_y, coasting);
    end
  endtask

  task automatic test_coast();
    int va, vc, ea, ec, ta; logic [W-1:0] zx, zy;
    for (int t = 1; t <= 3; t++) begin
      run_frame(14, 1'b0, '0, '0, 0, '0, '0, va, vc, ea, ec, ta, zx, zy);
      checks++;
      if (va !== 1 || zx !== 11'(100 + t) || zy !== 11'(200 + 2*t) || coasting !== 1'b1 || track_lost !== 1'b0) begin
        failures++;
        $display("FAIL coast_tick%0d actual at=%0d z=(%0d,%0d) coast=%b lost=%b required at=1 z=(%0d,%0d) coast=1 lost=0",
          t, va, zx, zy, coasting, track_lost, 100 + t, 200 + 2*t);
      end
    end
    run_frame(14, 1'b0, '0, '0, 0, '0, '0, va, vc, ea, ec, ta, zx, zy);
    checks++;
    if (vc !== 0 || ec !== 0 || track_lost !== 1'b1) begin
      failures++;
      $display("FAIL coast_lost actual issues=%0d ests=%0d lost=%b required 0 0 1", vc, ec, track_lost);
    end
    run_frame(14, 1'b1, 11'd50, 11'd60, 0, '0, '0, va, vc, ea, ec, ta, zx, zy);
    checks++;
    if (va !== 1 || zx !== 11'd50 || zy !== 11'd60 || track_lost !== 1'b0 || coasting !== 1'b0 ||
        est_x !== 11'd51 || est_y !== 11'd62) begin
      failures++;
      $display("FAIL coast_recover actual z=(%0d,%0d) lost=%b coast=%b est=(%0d,%0d) required z=(50,60) 0 0 est=(51,62)",
        zx, zy, track_lost, coasting, est_x, est_y);
    end
  endtask

  task automatic test_overwrite();
    int va, vc, ea, ec, ta; logic [W-1:0] zx, zy;
    load_meas(11'd10, 11'd10);
    load_meas(11'd20, 11'd20);
    run_frame(14, 1'b0, '0, '0, 0, '0, '0, va, vc, ea, ec, ta, zx, zy);
    checks++;
    if (zx !== 11'd20 || zy !== 11'd20 || vc !== 1) begin
      failures++;
      $display("FAIL overwrite actual z=(%0d,%0d) cnt=%0d required z=(20,20) cnt=1", zx, zy, vc);
    end
    load_meas(11'd30, 11'd30);
    run_frame(14, 1'b1, 11'd40, 11'd40, 0, '0, '0, va, vc, ea, ec, ta, zx, zy);
    checks++;
    if (zx !== 11'd40 || zy !== 11'd40 || est_x !== 11'd41 || est_y !== 11'd42) begin
      failures++;
      $display("FAIL same_cycle_meas actual z=(%0d,%0d) est=(%0d,%0d) required z=(40,40) est=(41,42)", zx, zy, est_x, est_y);
    end
  endtask

  task automatic test_overrun();
    int va, vc, ea, ec, ta; logic [W-1:0] zx, zy;
    run_frame(14, 1'b0, '0, '0, 3, 11'd9, 11'd9, va, vc, ea, ec, ta, zx, zy);
    checks++;
    if (overrun !== 1'b1 || vc !== 1 || ec !== 1 || ea !== 12 || zx !== 11'd41) begin
      failures++;
      $display("FAIL overrun actual ovr=%b issues=%0d ests=%0d est_at=%0d zx=%0d required 1 1 1 12 41",
        overrun, vc, ec, ea, zx);
    end
    run_frame(14, 1'b0, '0, '0, 0, '0, '0, va, vc, ea, ec, ta, zx, zy);
    checks++;
    if (zx !== 11'd9 || zy !== 11'd9 || coasting !== 1'b0 || est_x !== 11'd10 || est_y !== 11'd11) begin
      failures++;
      $display("FAIL overrun_buffered actual z=(%0d,%0d) coast=%b est=(%0d,%0d) required z=(9,9) 0 est=(10,11)",
        zx, zy, coasting, est_x, est_y);
    end
  endtask

  task automatic test_timeout();
    int va, vc, ea, ec, ta; logic [W-1:0] zx, zy;
    hang = 1'b1;
    run_frame(40, 1'b1, 11'd7, 11'd8, 0, '0, '0, va, vc, ea, ec, ta, zx, zy);
    checks++;
    if (ta !== 35 || ec !== 0 || busy !== 1'b0 || est_x !== 11'd10 || est_y !== 11'd11) begin
      failures++;
      $display("FAIL timeout actual to_at=%0d ests=%0d busy=%b est=(%0d,%0d) required 35 0 0 est=(10,11)",
        ta, ec, busy, est_x, est_y);
    end
    hang = 1'b0;
    wait_core_idle();
    run_frame(14, 1'b0, '0, '0, 0, '0, '0, va, vc, ea, ec, ta, zx, zy);
    checks++;
    if (va !== 1 || zx !== 11'd10 || zy !== 11'd11 || ea !== 12 || est_x !== 11'd11 || est_y !== 11'd13) begin
      failures++;
      $display("FAIL after_timeout actual at=%0d z=(%0d,%0d) est_at=%0d est=(%0d,%0d) required 1 (10,11) 12 (11,13)",
        va, zx, zy, ea, est_x, est_y);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    frame_tick = 1'b1; meas_valid = 1'b1; meas_x = 11'd5; meas_y = 11'd6;
    @(negedge clk);
    frame_tick = 1'b0; meas_valid = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({core_valid, est_valid, coasting, track_lost, overrun, timeout_err, busy} !== 7'b0 ||
        est_x !== '0 || est_y !== '0 || core_z_x !== '0 || core_z_y !== '0) begin
      failures++;
      $display("FAIL reset_mid actual flags=%b est=(%0d,%0d) z=(%0d,%0d) required all 0",
        {core_valid, est_valid, coasting, track_lost, overrun, timeout_err, busy},
        est_x, est_y, core_z_x, core_z_y);
    end
    wait_core_idle();
  endtask

`ifdef KALMAN_GATE_EN
  task automatic test_gate();
    int va, vc, ea, ec, ta; logic [W-1:0] zx, zy;
    run_frame(14, 1'b1, 11'd99, 11'd98, 0, '0, '0, va, vc, ea, ec, ta, zx, zy);
    run_frame(14, 1'b1, 11'd300, 11'd100, 0, '0, '0, va, vc, ea, ec, ta, zx, zy);
    checks++;
    if (zx !== 11'd100 || zy !== 11'd100 || coasting !== 1'b1) begin
      failures++;
      $display("FAIL gate_reject actual z=(%0d,%0d) coast=%b required z=(100,100) coast=1", zx, zy, coasting);
    end
    run_frame(14, 1'b1, 11'd150, 11'd90, 0, '0, '0, va, vc, ea, ec, ta, zx, zy);
    checks++;
    if (zx !== 11'd150 || zy !== 11'd90 || coasting !== 1'b0) begin
      failures++;
      $display("FAIL gate_accept actual z=(%0d,%0d) coast=%b required z=(150,90) coast=0", zx, zy, coasting);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_coast();
    test_overwrite();
    test_overrun();
    test_timeout();
    test_reset_mid();
`ifdef KALMAN_GATE_EN
    test_gate();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/kalman_frame_sched.md
Name: kalman_frame_sched

Overview:
- Frame-rate sequencer between the centroid detector and the Kalman filter core.
- Buffers at most one measurement per frame. On each frame tick, issues either that measurement or a coast value (last estimate) to the core over its valid/ready handshake.
- Tracks the core through busy and done, captures the new estimate, and publishes it with a one-cycle valid pulse.
- Provides coast/lost tracking, tick-overrun detection and a core watchdog.

Parameters:
- DISP_WIDTH, 11, coordinate width for measurements and estimates.
- MAX_COAST, 3, consecutive measurement-less frames tolerated before declaring track lost (1..15).
- TIMEOUT, 32, maximum cycles spent in WAIT_BUSY or in WAIT_DONE before aborting (≥16).
- GATE_DIST, 64, per-axis gate distance in pixels; used only when KALMAN_GATE_EN is defined.

Ports:
- clk  in  1  clock, all logic rising-edge
- reset  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per video frame
- meas_valid  in  1  new centroid present
- meas_x  in  DISP_WIDTH  centroid x
- meas_y  in  DISP_WIDTH  centroid y
- core_valid  out  1  issue strobe to the Kalman core
- core_ready  in  1  core idle indication
- core_z_x  out  DISP_WIDTH  value issued to the core (x)
- core_z_y  out  DISP_WIDTH  value issued to the core (y)
- core_x_new  in  DISP_WIDTH  core estimate (x)
- core_y_new  in  DISP_WIDTH  core estimate (y)
- est_x  out  DISP_WIDTH  latched estimate (x)
- est_y  out  DISP_WIDTH  latched estimate (y)
- est_valid  out  1  one-cycle pulse when est_x/est_y update
- coasting  out  1  last issue was a coast value
- track_lost  out  1  coast limit exceeded
- overrun  out  1  sticky: frame_tick arrived while not in IDLE
- timeout_err  out  1  sticky: core watchdog fired
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset (synchronous, active-high):
  - FSM enters IDLE.
  - All outputs are 0; buffer is empty; coast_cnt is 0.
  - Reset mid-operation abandons the in-flight issue. The core is not notified; the next issue waits for core_ready.
- Measurement buffer:
  - Single entry, always accepts input (no ready signal).
  - meas_valid loads meas_x/meas_y and sets buf_full. A newer measurement overwrites an older one.
  - buf_full clears on the cycle the FSM leaves IDLE.
  - meas_valid on the same cycle as frame_tick counts for that frame: the new value is issued.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, PUBLISH.
- IDLE, on frame_tick, measurement available (buf_full or a same-cycle meas_valid):
  - Select the buffered measurement, clear coast_cnt, coasting=0, track_lost=0, go to ISSUE.
- IDLE, on frame_tick, no measurement, track_lost=0:
  - If coast_cnt < MAX_COAST: select est_x/est_y, increment coast_cnt, coasting=1, go to ISSUE.
  - Otherwise: set track_lost=1 and stay in IDLE. Nothing is issued while lost.
- IDLE, on frame_tick, no measurement, track_lost=1: stay in IDLE.
- ISSUE:
  - core_z_x/core_z_y are registered from the selected value on IDLE exit and held stable from ISSUE until the next issue.
  - Wait for core_ready=1, then assert core_valid for exactly one cycle and go to WAIT_BUSY.
- WAIT_BUSY: when core_ready=0, go to WAIT_DONE.
- WAIT_DONE: when core_ready=1, go to PUBLISH.
- PUBLISH:
  - Capture core_x_new/core_y_new into est_x/est_y.
  - Pulse est_valid for one cycle, go to IDLE.
  - Latency: frame_tick to est_valid is 12 cycles with a ready core that turns around in 8 busy cycles (issue cycle + 1 cycle to busy + 8 busy + 1 done detect + publish).
- Watchdog:
  - A cycle counter resets on entry to WAIT_BUSY and again on entry to WAIT_DONE.
  - If it reaches TIMEOUT in either state: set timeout_err, return to IDLE, no est_valid, estimate unchanged.
- Overrun: frame_tick while busy=1 sets overrun and the tick is dropped. A measurement arriving then is still buffered.
- timeout_err and overrun clear only on reset.
- busy = (state != IDLE).

Optional Feature:
- KALMAN_GATE_EN defined:
  - Applies when a measurement is selected in IDLE, est has been published at least once, and track_lost=0.
  - If |meas_x - est_x| > GATE_DIST or |meas_y - est_y| > GATE_DIST, the measurement is rejected and the frame is handled as measurement-less (coast rules apply).
  - Differences are unsigned absolute values at DISP_WIDTH+1 bits.
- Undefined: no gating; every buffered measurement is issued.

Test Plan:
- Core model (ready drops 1 cycle after valid, busy 8 cycles): meas (100,200) then frame_tick → one core_valid with core_z=(100,200); est_valid 12 cycles after tick with est = core output; coasting=0.
- 4 ticks with no measurement, MAX_COAST=3 → ticks 1–3 issue the last est, coasting=1; tick 4 issues nothing and sets track_lost=1; next meas (50,60) plus tick → issued, track_lost=0.
- Measurements (10,10) then (20,20) before one tick → only (20,20) issued; meas_valid and tick on the same cycle → that cycle's value issued.
- Core holds ready low forever after valid, TIMEOUT=32 → timeout_err=1 after 32 cycles in WAIT_DONE, FSM back to IDLE, no est_valid; next tick issues normally.
- frame_tick 3 cycles after a previous tick → overrun=1, second tick dropped, exactly one est_valid; reset asserted in WAIT_DONE → all outputs 0 the next cycle.
- KALMAN_GATE_EN, est=(100,100), GATE_DIST=64: meas (300,100) → rejected and coasted; meas (150,90) → issued.
